radix_4_ntt_feeder: RTL

Upstream input stage for `radix_4_ntt_pe`. It accepts a serial coefficient stream over a valid/ready handshake and packs every four consecutive samples into one butterfly group. Each group carries its twiddle index and the frame's inverse flag. Groups are buffered in a two-entry ping-pong store, so input streaming continues while the PE side applies backpressure.

---
 rtl/radix_4_ntt_feeder.sv | 106 ++++++++++
 1 files changed

// File: rtl/radix_4_ntt_feeder.sv
// Packs a serial coefficient stream into four-lane butterfly groups held in a two-slot ping-pong buffer.
// Optional input reduction modulo Q is enabled by defining RADIX_4_NTT_FEEDER_MOD_REDUCE_EN.
module radix_4_ntt_feeder #(
  parameter int N = 17,
  parameter int POINTS = 16,
  parameter int Q = 65537,
  localparam int GROUPS = POINTS / 4,
  localparam int TW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_inv,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  output logic [N-1:0]  c,
  output logic [N-1:0]  d,
  output logic [TW-1:0] tf_idx,
  output logic          inv,
  output logic          last_group,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [N-1:0]  QN    = N'(Q);
  localparam logic [TW-1:0] GLAST = TW'(GROUPS - 1);

  logic [1:0]    lane;
  logic [TW-1:0] grp;
  logic [1:0]    count;
  logic          wptr;
  logic          rptr;
  logic          frame_inv;

  logic [N-1:0]  slot_d [2][4];
  logic [TW-1:0] slot_tf [2];
  logic          slot_inv [2];
  logic          slot_last [2];

  logic          acc;
  logic          commit;
  logic          pop;
  logic [N-1:0]  sample;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid && in_ready;
  assign commit    = acc && (lane == 2'd3);
  assign pop       = out_valid && out_ready;

  // A single conditional subtract suffices since 2^N-1 < 2Q.
  always_comb begin
    sample = in_data;
`ifdef RADIX_4_NTT_FEEDER_MOD_REDUCE_EN
    if (in_data >= QN) sample = in_data - QN;
`endif
  end

  assign a          = slot_d[rptr][0];
  assign b          = slot_d[rptr][1];
  assign c          = slot_d[rptr][2];
  assign d          = slot_d[rptr][3];
  assign tf_idx     = slot_tf[rptr];
  assign inv        = slot_inv[rptr];
  assign last_group = slot_last[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= 2'd0;
      grp       <= '0;
      count     <= 2'd0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      frame_inv <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        for (int l = 0; l < 4; l++) slot_d[s][l] <= '0;
        slot_tf[s]   <= '0;
        slot_inv[s]  <= 1'b0;
        slot_last[s] <= 1'b0;
      end
    end else begin
      // The write slot is never the one being read while count < 2, so lanes fill in place.
      if (acc) begin
        slot_d[wptr][lane] <= sample;
        lane <= lane + 2'd1;
        if (lane == 2'd0 && grp == '0) frame_inv <= in_inv;
      end
      if (commit) begin
        slot_tf[wptr]   <= grp;
        slot_inv[wptr]  <= frame_inv;
        slot_last[wptr] <= (grp == GLAST);
        grp  <= (grp == GLAST) ? '0 : grp + 1'b1;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({commit, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
